// File: rtl/sweep_controller_if.sv
// -----------------------------------------------------------------------------
// sweep_controller_if
// Groups the host and counter signals of the triangle-sweep sequencer.
//   master : host/environment side. Drives start, abort, lo, hi, n_sweeps and
//            the counter value cnt. Observes dir, zero, busy, done, err,
//            sync_err and sweep_cnt.
//   slave  : sweep_controller side (directions mirrored).
// Parameters: W = counter width, NW = sweep-count width.
// -----------------------------------------------------------------------------
interface sweep_controller_if #(
    parameter int W  = 16,
    parameter int NW = 8
);
    logic          start;
    logic          abort;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
    logic [NW-1:0] n_sweeps;
    logic [W-1:0]  cnt;
    logic          dir;
    logic          zero;
    logic          busy;
    logic          done;
    logic          err;
    logic          sync_err;
    logic [NW-1:0] sweep_cnt;

    modport master (
        output start, abort, lo, hi, n_sweeps, cnt,
        input  dir, zero, busy, done, err, sync_err, sweep_cnt
    );

    modport slave (
        input  start, abort, lo, hi, n_sweeps, cnt,
        output dir, zero, busy, done, err, sync_err, sweep_cnt
    );
endinterface

// File: rtl/sweep_controller.sv
// -----------------------------------------------------------------------------
// sweep_controller
// Drives an external up/down counter (dir/zero) to produce a triangle sweep
// between lo and hi, repeated n_sweeps times. The first rise starts at 0.
// A shadow copy of the counter is kept and compared against the counter
// value every active cycle; any difference raises a sticky sync_err.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sweep_controller_if.slave
//          start/abort/lo/hi/n_sweeps/cnt in; dir/zero/busy/done/err/
//          sync_err/sweep_cnt out (all outputs registered)
// -----------------------------------------------------------------------------
module sweep_controller #(
    parameter int W  = 16,
    parameter int NW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sweep_controller_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  ZERO_W  = {W{1'b0}};
    localparam logic [NW-1:0] ONE_NW  = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] ZERO_NW = {NW{1'b0}};

    state_t        state_q,     state_d;
    logic [W-1:0]  lo_q,        lo_d;
    logic [W-1:0]  hi_q,        hi_d;
    logic [NW-1:0] n_q,         n_d;
    logic [NW-1:0] sweep_cnt_q, sweep_cnt_d;
    logic [W-1:0]  shadow_q,    shadow_d;
    logic          sync_err_q,  sync_err_d;
    logic          err_q,       err_d;
    logic          dir_q,       dir_d;
    logic          zero_q,      zero_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;

    logic          accept_s;
    logic [W-1:0]  hi_m1_s;
    logic [W-1:0]  lo_p1_s;
    logic [NW-1:0] sweep_inc_s;

    // Next-state, latched-configuration and registered-output decode.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        n_d         = n_q;
        sweep_cnt_d = sweep_cnt_q;
        sync_err_d  = sync_err_q;
        err_d       = 1'b0;

        // lo < hi is enforced at accept, so neither turn value can wrap.
        hi_m1_s     = hi_q - ONE_W;
        lo_p1_s     = lo_q + ONE_W;
        sweep_inc_s = sweep_cnt_q + ONE_NW;
        accept_s    = (bus.lo < bus.hi) && (bus.n_sweeps != ZERO_NW) &&
                      (bus.cnt == ZERO_W);

        // Shadow follows the counter contract using the dir/zero we drive.
        if (zero_q) begin
            shadow_d = ZERO_W;
        end else if (dir_q) begin
            shadow_d = shadow_q + ONE_W;
        end else begin
            shadow_d = shadow_q - ONE_W;
        end

        if ((state_q != S_IDLE) && (bus.cnt != shadow_q)) begin
            sync_err_d = 1'b1;
        end else begin
            sync_err_d = sync_err_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start && accept_s) begin
                    lo_d        = bus.lo;
                    hi_d        = bus.hi;
                    n_d         = bus.n_sweeps;
                    sweep_cnt_d = ZERO_NW;
                    sync_err_d  = 1'b0;
                    shadow_d    = ZERO_W;
                    state_d     = S_RISE;
                end else if (bus.start) begin
                    err_d       = 1'b1;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_RISE: begin
                // Abort has priority over the turn at the peak.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.cnt == hi_m1_s) begin
                    state_d = S_FALL;
                end else begin
                    state_d = S_RISE;
                end
            end
            S_FALL: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.cnt == lo_p1_s) begin
                    sweep_cnt_d = sweep_inc_s;
                    if (sweep_inc_s == n_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RISE;
                    end
                end else begin
                    state_d = S_FALL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are Moore decodes of the state being entered.
        dir_d  = (state_d == S_RISE);
        zero_d = (state_d == S_IDLE) || (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lo_q        <= ZERO_W;
            hi_q        <= ZERO_W;
            n_q         <= ZERO_NW;
            sweep_cnt_q <= ZERO_NW;
            shadow_q    <= ZERO_W;
            sync_err_q  <= 1'b0;
            err_q       <= 1'b0;
            dir_q       <= 1'b0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            n_q         <= n_d;
            sweep_cnt_q <= sweep_cnt_d;
            shadow_q    <= shadow_d;
            sync_err_q  <= sync_err_d;
            err_q       <= err_d;
            dir_q       <= dir_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.dir       = dir_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.sweep_cnt = sweep_cnt_q;

endmodule
